// File: rtl/ifetch_stage_if.sv
// ----------------------------------------------------------------------------
// ifetch_stage_if
//
// Bundles every non-clock/reset signal of the instruction fetch stage.
//
// Instruction-memory side (fetch stage is the requester):
//   imem_req     fetch request valid
//   imem_addr    word-aligned fetch address
//   imem_gnt     memory accepted the request this cycle
//   imem_rvalid  read data valid, in order, at least one cycle after grant
//   imem_rdata   instruction word
//
// Decode / control side:
//   stall        decode cannot accept a new instruction this cycle
//   redirect     branch taken, refetch from redirect_pc
//   redirect_pc  branch target (bits [1:0] ignored)
//   instr        current instruction to decode
//   instr_pc     address of instr
//   pc_plus4     instr_pc + 4
//   instr_valid  instr/instr_pc/pc_plus4 are meaningful
//   opcode       instr[31:26] while valid, 6'b111111 on a bubble
//
// Modports:
//   master  the fetch stage
//   slave   the environment (instruction memory plus decode)
// ----------------------------------------------------------------------------
interface ifetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic [5:0]  opcode;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  stall, redirect, redirect_pc,
    output instr, instr_pc, pc_plus4, instr_valid, opcode
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output stall, redirect, redirect_pc,
    input  instr, instr_pc, pc_plus4, instr_valid, opcode
  );
endinterface

// File: rtl/ifetch_stage.sv
// ----------------------------------------------------------------------------
// ifetch_stage
//
// Instruction fetch stage in front of decode and the control unit. Holds the
// PC, keeps at most one word fetch outstanding on a request/grant/response
// memory handshake, and presents the fetched instruction, its PC and PC+4.
// A one-entry hold buffer absorbs a response that arrives while decode is
// stalled. A branch redirect flushes the output slot and the hold buffer;
// a request already granted to memory is drained and its data dropped.
//
// Parameters:
//   RESET_PC  PC loaded on reset
//
// Ports:
//   clock  system clock, all state on the rising edge
//   reset  asynchronous, active-high
//   bus    ifetch_stage_if.master (memory handshake + decode interface)
// ----------------------------------------------------------------------------
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clock,
  input  logic           reset,
  ifetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // request outstanding on the bus, waiting for grant
    ST_WAIT  = 2'd1,  // granted, waiting for the response
    ST_HOLD  = 2'd2,  // response parked in the hold buffer behind a stall
    ST_DRAIN = 2'd3   // granted request went stale, swallow its response
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_pc, req_pc_nxt;

  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic [31:0] pc_plus4_q;
  logic        instr_valid_q, instr_valid_nxt;

  logic [31:0] hold_instr;
  logic [31:0] hold_pc;

  logic        drain;        // decode takes the current output this cycle
  logic        slot_free;    // output registers may be overwritten this cycle
  logic        load_mem;     // output <- memory response
  logic        load_hold;    // output <- hold buffer
  logic        capture_hold; // hold buffer <- memory response
  logic        clear_hold;

  // The low target bits are architecturally ignored.
  logic        unused_redirect_bits;
  assign unused_redirect_bits = ^bus.redirect_pc[1:0];

  assign drain     = instr_valid_q & ~bus.stall;
  assign slot_free = ~instr_valid_q | drain;

  // --------------------------------------------------------------------------
  // Next-state and datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_nxt    = state;
    pc_nxt       = pc;
    req_pc_nxt   = req_pc;
    load_mem     = 1'b0;
    load_hold    = 1'b0;
    capture_hold = 1'b0;
    clear_hold   = 1'b0;

    case (state)
      ST_FETCH: begin
        if (bus.imem_gnt) begin
          req_pc_nxt = pc;
          pc_nxt     = pc + 32'd4;
          state_nxt  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rvalid) begin
          if (slot_free) begin
            load_mem  = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            capture_hold = 1'b1;
            state_nxt    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // In HOLD the slot is always occupied, so stall low means it drains
        // and the parked word can move in behind it in the same cycle.
        if (!bus.stall) begin
          load_hold = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (bus.imem_rvalid) begin
          state_nxt = ST_FETCH;
        end
      end
      default: state_nxt = ST_FETCH;
    endcase

    // Redirect overrides everything above. A request granted this very cycle
    // is still owed a response, so it must be drained; a response arriving
    // this very cycle closes the outstanding request, so fetching can resume.
    if (bus.redirect) begin
      pc_nxt       = {bus.redirect_pc[31:2], 2'b00};
      load_mem     = 1'b0;
      load_hold    = 1'b0;
      capture_hold = 1'b0;
      clear_hold   = 1'b1;
      case (state)
        ST_FETCH: state_nxt = bus.imem_gnt    ? ST_DRAIN : ST_FETCH;
        ST_WAIT:  state_nxt = bus.imem_rvalid ? ST_FETCH : ST_DRAIN;
        ST_HOLD:  state_nxt = ST_FETCH;
        ST_DRAIN: state_nxt = bus.imem_rvalid ? ST_FETCH : ST_DRAIN;
        default:  state_nxt = ST_FETCH;
      endcase
    end

    if (bus.redirect) begin
      instr_valid_nxt = 1'b0;
    end else if (load_mem || load_hold) begin
      instr_valid_nxt = 1'b1;
    end else if (drain) begin
      instr_valid_nxt = 1'b0;
    end else begin
      instr_valid_nxt = instr_valid_q;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_FETCH;
      pc            <= RESET_PC;
      req_pc        <= 32'h0;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      pc_plus4_q    <= 32'h0;
      instr_valid_q <= 1'b0;
      // NOTE: the hold buffer is plain flops rather than a memory array, so
      // it is cleared on reset like everything else and never shows X.
      hold_instr    <= 32'h0;
      hold_pc       <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments only, so every flop samples values
      // from before the edge regardless of statement order.
      state         <= state_nxt;
      pc            <= pc_nxt;
      req_pc        <= req_pc_nxt;
      instr_valid_q <= instr_valid_nxt;

      if (load_mem) begin
        instr_q    <= bus.imem_rdata;
        instr_pc_q <= req_pc;
        pc_plus4_q <= req_pc + 32'd4;
      end else if (load_hold) begin
        instr_q    <= hold_instr;
        instr_pc_q <= hold_pc;
        pc_plus4_q <= hold_pc + 32'd4;
      end

      if (clear_hold) begin
        hold_instr <= 32'h0;
        hold_pc    <= 32'h0;
      end else if (capture_hold) begin
        hold_instr <= bus.imem_rdata;
        hold_pc    <= req_pc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.imem_req    = (state == ST_FETCH);
  assign bus.imem_addr   = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.pc_plus4    = pc_plus4_q;
  assign bus.instr_valid = instr_valid_q;
  // All-ones opcode belongs to no instruction class, so a bubble drives every
  // control-unit output low.
  assign bus.opcode      = instr_valid_q ? instr_q[31:26] : 6'b11_1111;

endmodule

// File: tb/tb_ifetch_stage.sv
// ----------------------------------------------------------------------------
// tb_ifetch_stage
//
// Two fetch stages share clock and reset: dut_lo (RESET_PC = 0) receives the
// directed and random stimulus; dut_hi (RESET_PC = 0xFFFFFFFC) free-runs
// against an always-granting 1-cycle memory to exercise PC wrap-around.
// Fetch addresses are pushed to a scoreboard when granted and popped when
// decode consumes the instruction; a redirect or reset empties it.
// ----------------------------------------------------------------------------
module tb_ifetch_stage;

  localparam logic [31:0] RESET_LO = 32'h0000_0000;
  localparam logic [31:0] RESET_HI = 32'hFFFF_FFFC;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ifetch_stage_if lo_if ();
  ifetch_stage_if hi_if ();

  ifetch_stage #(.RESET_PC(RESET_LO)) dut_lo (
    .clock (clock),
    .reset (reset),
    .bus   (lo_if)
  );

  ifetch_stage #(.RESET_PC(RESET_HI)) dut_hi (
    .clock (clock),
    .reset (reset),
    .bus   (hi_if)
  );

  int errors = 0;
  int checks = 0;

  // stimulus controls
  bit          rst_c;
  bit          stall_c;
  bit          redirect_c;
  logic [31:0] redirect_pc_c;
  bit          gnt_en;
  int          lat;

  // lo memory model and scoreboard
  bit          pend;
  int          cnt;
  logic [31:0] paddr;
  logic [31:0] exp_pc;
  logic [31:0] sb_q[$];
  bit          grant_seen;

  // hi memory model and observations
  bit          hpend;
  logic [31:0] hpaddr;
  logic [31:0] hi_gaddr[$];
  bit          hi_seen;
  logic [31:0] hi_first_pc, hi_first_p4, hi_first_instr;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[7:2] ^ 6'h15, ~a[25:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, score, advance memory models after posedge.
  task automatic cycle();
    bit          rv, gnt_s, hgnt_s, hrv;
    logic [31:0] gaddr, hgaddr, e, w;
    @(negedge clock);
    reset = rst_c;
    lo_if.stall       = stall_c;
    lo_if.redirect    = redirect_c;
    lo_if.redirect_pc = redirect_pc_c;
    rv = pend && (cnt <= 1);
    lo_if.imem_rvalid = rv;
    lo_if.imem_rdata  = rv ? word(paddr) : 32'hDEAD_BEEF;
    lo_if.imem_gnt    = gnt_en && lo_if.imem_req;
    hrv = hpend;
    hi_if.imem_rvalid = hrv;
    hi_if.imem_rdata  = hrv ? word(hpaddr) : 32'h0;
    hi_if.imem_gnt    = hi_if.imem_req;
    #1;
    gnt_s  = gnt_en && lo_if.imem_req;
    gaddr  = lo_if.imem_addr;
    hgnt_s = hi_if.imem_req;
    hgaddr = hi_if.imem_addr;

    if (!rst_c) begin
      if (lo_if.imem_req) check("imem_addr", lo_if.imem_addr, exp_pc);
      if (lo_if.instr_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", {31'b0, lo_if.instr_valid}, 32'h0);
        end else begin
          e = sb_q[0];
          w = word(e);
          check("instr_pc", lo_if.instr_pc, e);
          check("instr", lo_if.instr, w);
          check("pc_plus4", lo_if.pc_plus4, e + 32'd4);
          check("opcode", {26'b0, lo_if.opcode}, {26'b0, w[31:26]});
          if (!stall_c && !redirect_c) void'(sb_q.pop_front());
        end
      end else begin
        check("opcode_bubble", {26'b0, lo_if.opcode}, 32'h3F);
      end
    end

    grant_seen = gnt_s && !redirect_c && !rst_c;
    if (rst_c) begin
      sb_q.delete();
      exp_pc = RESET_LO;
    end else if (redirect_c) begin
      sb_q.delete();
      exp_pc = redirect_pc_c & ~32'd3;
    end else if (gnt_s) begin
      sb_q.push_back(exp_pc);
      exp_pc = exp_pc + 32'd4;
    end

    if (!rst_c) begin
      if (hgnt_s) hi_gaddr.push_back(hgaddr);
      if (hi_if.instr_valid && !hi_seen) begin
        hi_seen        = 1'b1;
        hi_first_pc    = hi_if.instr_pc;
        hi_first_p4    = hi_if.pc_plus4;
        hi_first_instr = hi_if.instr;
      end
    end

    @(posedge clock);
    if (rst_c) begin
      pend  = 1'b0;
      hpend = 1'b0;
    end else begin
      if (rv) pend = 1'b0;
      else if (pend) cnt--;
      if (gnt_s) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = gaddr;
      end
      if (hrv) hpend = 1'b0;
      if (hgnt_s) begin
        hpend  = 1'b1;
        hpaddr = hgaddr;
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},    {31'b0, lo_if.instr_valid}, 32'h0);
    check({tag, "_instr"},    lo_if.instr, 32'h0);
    check({tag, "_instr_pc"}, lo_if.instr_pc, 32'h0);
    check({tag, "_pc_plus4"}, lo_if.pc_plus4, 32'h0);
    check({tag, "_opcode"},   {26'b0, lo_if.opcode}, 32'h3F);
    check({tag, "_req"},      {31'b0, lo_if.imem_req}, 32'h1);
    check({tag, "_addr"},     lo_if.imem_addr, RESET_LO);
    check({tag, "_hi_valid"}, {31'b0, hi_if.instr_valid}, 32'h0);
    check({tag, "_hi_addr"},  hi_if.imem_addr, RESET_HI);
  endtask

  initial begin
    bit found;
    lo_if.imem_gnt = 1'b0; lo_if.imem_rvalid = 1'b0; lo_if.imem_rdata = 32'h0;
    lo_if.stall = 1'b0; lo_if.redirect = 1'b0; lo_if.redirect_pc = 32'h0;
    hi_if.imem_gnt = 1'b0; hi_if.imem_rvalid = 1'b0; hi_if.imem_rdata = 32'h0;
    hi_if.stall = 1'b0; hi_if.redirect = 1'b0; hi_if.redirect_pc = 32'h0;
    rst_c = 1'b1; stall_c = 1'b0; redirect_c = 1'b0; redirect_pc_c = 32'h0;
    gnt_en = 1'b1; lat = 1; exp_pc = RESET_LO;

    // reset state
    run(2);
    check_reset_outputs("rst0");
    rst_c = 1'b0;

    // streaming: 0, 4 fetched back to back
    run(4);
    check("stream_valid4", {31'b0, lo_if.instr_valid}, 32'h1);
    check("stream_pc4", lo_if.instr_pc, 32'h4);

    // stall 5 cycles while @4 is valid and the @8 response arrives
    stall_c = 1'b1;
    run(1);
    check("stall_wait_req", {31'b0, lo_if.imem_req}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      run(1);
      check("hold_req", {31'b0, lo_if.imem_req}, 32'h0);
      check("hold_pc", lo_if.instr_pc, 32'h4);
    end
    stall_c = 1'b0; lat = 2;
    run(1);
    check("unhold_valid", {31'b0, lo_if.instr_valid}, 32'h1);
    check("unhold_pc", lo_if.instr_pc, 32'h8);

    // fetch 0xC granted, redirect to 0x100 while waiting
    run(1);
    redirect_c = 1'b1; redirect_pc_c = 32'h100;
    run(1);
    redirect_c = 1'b0; lat = 1;
    check("drain1_req", {31'b0, lo_if.imem_req}, 32'h0);
    run(1);
    check("drain1_novalid", {31'b0, lo_if.instr_valid}, 32'h0);
    check("drain1_next", lo_if.imem_addr, 32'h100);
    run(2);
    check("after_redir_pc", lo_if.instr_pc, 32'h100);

    // redirect to 0x10 while not granted, then 0x203 together with the grant
    gnt_en = 1'b0; redirect_c = 1'b1; redirect_pc_c = 32'h10;
    run(1);
    check("redir_kill_valid", {31'b0, lo_if.instr_valid}, 32'h0);
    check("redir_addr10", lo_if.imem_addr, 32'h10);
    gnt_en = 1'b1; redirect_pc_c = 32'h203; lat = 2;
    run(1);
    redirect_c = 1'b0;
    check("drain2_req_a", {31'b0, lo_if.imem_req}, 32'h0);
    run(1);
    check("drain2_req_b", {31'b0, lo_if.imem_req}, 32'h0);
    run(1);
    lat = 1;
    check("drain2_req_c", {31'b0, lo_if.imem_req}, 32'h1);
    check("drain2_addr", lo_if.imem_addr, 32'h200);

    // random stall / redirect / latency mix
    for (int i = 0; i < 80; i++) begin
      stall_c       = ($urandom_range(0, 3) == 0);
      redirect_c    = ($urandom_range(0, 11) == 0);
      redirect_pc_c = $urandom;
      lat           = $urandom_range(1, 3);
      run(1);
    end
    stall_c = 1'b0; redirect_c = 1'b0; lat = 3;

    // reset while in WAIT
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      run(1);
      found = grant_seen;
    end
    check("grant_wait_budget", {31'b0, found}, 32'h1);
    check("wait_req", {31'b0, lo_if.imem_req}, 32'h0);
    rst_c = 1'b1;
    run(1);
    check_reset_outputs("rst_wait");

    // reset while in HOLD
    rst_c = 1'b0; stall_c = 1'b1; lat = 1;
    run(5);
    check("pre_hold_req", {31'b0, lo_if.imem_req}, 32'h0);
    check("pre_hold_valid", {31'b0, lo_if.instr_valid}, 32'h1);
    check("pre_hold_pc", lo_if.instr_pc, 32'h0);
    rst_c = 1'b1;
    run(1);
    check_reset_outputs("rst_hold");
    rst_c = 1'b0; stall_c = 1'b0;
    run(6);

    // wrap-around instance
    check("hi_seen", {31'b0, hi_seen}, 32'h1);
    check("hi_first_pc", hi_first_pc, 32'hFFFF_FFFC);
    check("hi_first_p4", hi_first_p4, 32'h0);
    check("hi_first_instr", hi_first_instr, word(32'hFFFF_FFFC));
    check("hi_grants", (hi_gaddr.size() >= 2) ? 32'h1 : 32'h0, 32'h1);
    if (hi_gaddr.size() >= 2) begin
      check("hi_addr0", hi_gaddr[0], 32'hFFFF_FFFC);
      check("hi_addr1", hi_gaddr[1], 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
